// File: rtl/regs_wb_sched.sv
// regs_wb_sched: GPR write-port scheduler and scoreboard.
//   Shares the register file's single write port between EXU (port A) and
//   LSU (port B) with round-robin arbitration. It tracks the destinations of
//   issued instructions that are not yet written back, and stalls issue on
//   RAW/WAW hazards.
//   Ports: clk_i/rst_i (async active-low reset); iss_* issue-side hazard query
//   with iss_stall_o; a_*/b_* writeback requesters with ready handshakes;
//   wen_o/rd_o/wdata_o register-file write port (one cycle after the grant);
//   pending_o is the scoreboard vector.
//   Optional macro YSYX_23060251_WB_BYPASS_EN adds fwd{1,2}_en_o/fwd{1,2}_data_o.
//   It also lets a source read the value being written in the wen_o cycle.
module regs_wb_sched #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    parameter int RW     = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iss_valid_i,
    input  logic              iss_wen_i,
    input  logic [RW-1:0]     iss_rd_i,
    input  logic [RW-1:0]     iss_rs1_i,
    input  logic [RW-1:0]     iss_rs2_i,
    output logic              iss_stall_o,
    input  logic              a_valid_i,
    input  logic [RW-1:0]     a_rd_i,
    input  logic [XLEN-1:0]   a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [RW-1:0]     b_rd_i,
    input  logic [XLEN-1:0]   b_data_i,
    output logic              b_ready_o,
    output logic              wen_o,
    output logic [RW-1:0]     rd_o,
    output logic [XLEN-1:0]   wdata_o,
`ifdef YSYX_23060251_WB_BYPASS_EN
    output logic              fwd1_en_o,
    output logic              fwd2_en_o,
    output logic [XLEN-1:0]   fwd1_data_o,
    output logic [XLEN-1:0]   fwd2_data_o,
`endif
    output logic [NR_REG-1:0] pending_o
);
    logic              r_prio_b;
    logic              r_wen;
    logic [RW-1:0]     r_rd;
    logic [XLEN-1:0]   r_wdata;
    logic [NR_REG-1:0] r_pend;
    logic [NR_REG-1:0] w_rd_dec, w_rs1_dec, w_rs2_dec, w_wb_dec, w_a_dec, w_b_dec;
    logic [NR_REG-1:0] w_set, w_clr;
    logic              w_gnt_a, w_gnt_b, w_gnt, w_fire, w_raw1, w_raw2, w_waw;
    logic [RW-1:0]     w_gnt_rd;
    logic [XLEN-1:0]   w_gnt_data;

    // One-hot decodes. Indices >= NR_REG match no bit, so the scoreboard ignores them.
    for (genvar g = 0; g < NR_REG; g++) begin : g_dec
        assign w_rd_dec[g]  = iss_rd_i  == RW'(g);
        assign w_rs1_dec[g] = iss_rs1_i == RW'(g);
        assign w_rs2_dec[g] = iss_rs2_i == RW'(g);
        assign w_wb_dec[g]  = r_rd      == RW'(g);
        assign w_a_dec[g]   = a_rd_i    == RW'(g);
        assign w_b_dec[g]   = b_rd_i    == RW'(g);
    end

    // r_prio_b means B wins a tie. Grants are gated by rst_i so neither port is acked in reset.
    assign w_gnt_a    = rst_i & a_valid_i & (~b_valid_i | ~r_prio_b);
    assign w_gnt_b    = rst_i & b_valid_i & (~a_valid_i | r_prio_b);
    assign w_gnt      = w_gnt_a | w_gnt_b;
    assign w_gnt_rd   = w_gnt_a ? a_rd_i : b_rd_i;
    assign w_gnt_data = w_gnt_a ? a_data_i : b_data_i;
    assign a_ready_o  = w_gnt_a;
    assign b_ready_o  = w_gnt_b;

    // r_pend[0] never sets, so a source of x0 can never hit.
`ifdef YSYX_23060251_WB_BYPASS_EN
    assign fwd1_en_o   = r_wen & (r_rd == iss_rs1_i);
    assign fwd2_en_o   = r_wen & (r_rd == iss_rs2_i);
    assign fwd1_data_o = r_wdata;
    assign fwd2_data_o = r_wdata;
    assign w_raw1      = |(r_pend & w_rs1_dec) & ~fwd1_en_o;
    assign w_raw2      = |(r_pend & w_rs2_dec) & ~fwd2_en_o;
`else
    assign w_raw1      = |(r_pend & w_rs1_dec);
    assign w_raw2      = |(r_pend & w_rs2_dec);
`endif
    assign w_waw       = iss_wen_i & |(r_pend & w_rd_dec);
    assign iss_stall_o = iss_valid_i & (w_raw1 | w_raw2 | w_waw);
    assign w_fire      = iss_valid_i & iss_wen_i & ~iss_stall_o;
    assign w_set       = {NR_REG{w_fire}} & w_rd_dec & {{(NR_REG-1){1'b1}}, 1'b0};
    assign w_clr       = {NR_REG{r_wen}} & w_wb_dec;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prio_b <= 1'b0;
            r_wen    <= 1'b0;
            r_rd     <= '0;
            r_wdata  <= '0;
            r_pend   <= '0;
        end else begin
            r_wen  <= w_gnt & (w_gnt_rd != '0);
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_gnt) begin
                r_prio_b <= w_gnt_a;
                r_rd     <= w_gnt_rd;
                r_wdata  <= w_gnt_data;
            end
        end
    end

    assign wen_o     = r_wen;
    assign rd_o      = r_rd;
    assign wdata_o   = r_wdata;
    assign pending_o = r_pend;

    a_no_set_clr: assert property (@(posedge clk_i) disable iff (!rst_i) !(|(w_set & w_clr)));
    a_wb_pending: assert property (@(posedge clk_i) disable iff (!rst_i) r_wen |-> |(r_pend & w_wb_dec));
    a_iss_range:  assert property (@(posedge clk_i) disable iff (!rst_i)
                                   iss_valid_i |-> ((|w_rd_dec) & (|w_rs1_dec) & (|w_rs2_dec)));
    a_a_range:    assert property (@(posedge clk_i) disable iff (!rst_i) a_valid_i |-> |w_a_dec);
    a_b_range:    assert property (@(posedge clk_i) disable iff (!rst_i) b_valid_i |-> |w_b_dec);
endmodule

// File: tb/tb_regs_wb_sched.sv
// tb_regs_wb_sched: directed and random checks of regs_wb_sched against a behavioural model
module tb_regs_wb_sched;
    localparam int XLEN = 32, NR_REG = 32, RW = 5;
    logic clk_i = 1'b0, rst_i = 1'b0;
    logic iss_valid_i = 0, iss_wen_i = 0, a_valid_i = 0, b_valid_i = 0;
    logic [RW-1:0] iss_rd_i = 0, iss_rs1_i = 0, iss_rs2_i = 0, a_rd_i = 0, b_rd_i = 0;
    logic [XLEN-1:0] a_data_i = 0, b_data_i = 0;
    logic iss_stall_o, a_ready_o, b_ready_o, wen_o;
    logic [RW-1:0] rd_o;
    logic [XLEN-1:0] wdata_o;
    logic [NR_REG-1:0] pending_o;
`ifdef YSYX_23060251_WB_BYPASS_EN
    logic fwd1_en_o, fwd2_en_o;
    logic [XLEN-1:0] fwd1_data_o, fwd2_data_o;
`endif
    always #5 clk_i = ~clk_i;

    regs_wb_sched #(.XLEN(XLEN), .NR_REG(NR_REG), .RW(RW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iss_valid_i(iss_valid_i), .iss_wen_i(iss_wen_i), .iss_rd_i(iss_rd_i),
        .iss_rs1_i(iss_rs1_i), .iss_rs2_i(iss_rs2_i), .iss_stall_o(iss_stall_o),
        .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o),
`ifdef YSYX_23060251_WB_BYPASS_EN
        .fwd1_en_o(fwd1_en_o), .fwd2_en_o(fwd2_en_o),
        .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o),
`endif
        .pending_o(pending_o)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: set of in-flight destinations, last-granted port, and
    // the write that is due on the register-file port this cycle.
    logic [NR_REG-1:0] m_pend = '0;
    bit                m_last_a = 0;
    bit                m_wen = 0;
    logic [RW-1:0]     m_rd = '0;
    logic [XLEN-1:0]   m_wdata = '0;
    bit                e_ga, e_gb, e_r1, e_r2, e_ww, e_f1, e_f2, e_stall;
    logic [RW-1:0]     g_rd;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("rst_wen", wen_o, 0);
            chk("rst_rd", rd_o, 0);
            chk("rst_wdata", wdata_o, 0);
            chk("rst_pending", pending_o, 0);
            chk("rst_a_ready", a_ready_o, 0);
            chk("rst_b_ready", b_ready_o, 0);
            m_pend = '0; m_last_a = 0; m_wen = 0; m_rd = '0; m_wdata = '0;
        end else begin
            e_ga = a_valid_i && (!b_valid_i || !m_last_a);
            e_gb = b_valid_i && (!a_valid_i || m_last_a);
            e_f1 = m_wen && m_rd == iss_rs1_i;
            e_f2 = m_wen && m_rd == iss_rs2_i;
            e_r1 = iss_rs1_i != 0 && m_pend[iss_rs1_i];
            e_r2 = iss_rs2_i != 0 && m_pend[iss_rs2_i];
`ifdef YSYX_23060251_WB_BYPASS_EN
            e_r1 = e_r1 && !e_f1;
            e_r2 = e_r2 && !e_f2;
            chk("m_fwd1_en", fwd1_en_o, e_f1);
            chk("m_fwd2_en", fwd2_en_o, e_f2);
            chk("m_fwd1_data", fwd1_data_o, m_wdata);
            chk("m_fwd2_data", fwd2_data_o, m_wdata);
`endif
            e_ww = iss_wen_i && m_pend[iss_rd_i];
            e_stall = iss_valid_i && (e_r1 || e_r2 || e_ww);
            chk("m_a_ready", a_ready_o, e_ga);
            chk("m_b_ready", b_ready_o, e_gb);
            chk("m_stall", iss_stall_o, e_stall);
            chk("m_wen", wen_o, m_wen);
            chk("m_rd", rd_o, m_rd);
            chk("m_wdata", wdata_o, m_wdata);
            chk("m_pending", pending_o, m_pend);
            if (m_wen) m_pend[m_rd] = 1'b0;
            if (iss_valid_i && iss_wen_i && !e_stall && iss_rd_i != 0) m_pend[iss_rd_i] = 1'b1;
            if (e_ga || e_gb) begin
                g_rd = e_ga ? a_rd_i : b_rd_i;
                m_wen = g_rd != 0;
                m_rd = g_rd;
                m_wdata = e_ga ? a_data_i : b_data_i;
                m_last_a = e_ga;
            end else m_wen = 0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_iss(input bit v, input bit w, input int rd, input int rs1, input int rs2);
        iss_valid_i = v; iss_wen_i = w;
        iss_rd_i = RW'(rd); iss_rs1_i = RW'(rs1); iss_rs2_i = RW'(rs2);
    endtask

    function automatic int rnd_idx();
        return ($urandom_range(3) == 0) ? int'($urandom_range(31)) : int'($urandom_range(7));
    endfunction

    logic [RW-1:0] qa[$], qb[$];
    bit s_stall, s_ar, s_br;

    initial begin
        a_valid_i = 1;
        repeat (2) @(negedge clk_i);
        chk("reset_a_ready", a_ready_o, 0);
        chk("reset_wen", wen_o, 0);
        step();
        rst_i = 1; a_valid_i = 0;
        // Round-robin: A first after reset, then alternating while both request.
        set_iss(1, 1, 1, 0, 0); step();
        set_iss(1, 1, 2, 0, 0); step();
        set_iss(1, 1, 5, 0, 0); step();
        set_iss(1, 1, 6, 0, 0); step();
        set_iss(1, 1, 8, 0, 0); step();
        set_iss(0, 0, 0, 0, 0);
        a_valid_i = 1; a_rd_i = 1; a_data_i = 32'hA000_0001;
        b_valid_i = 1; b_rd_i = 2; b_data_i = 32'hB000_0002;
        @(negedge clk_i); chk("rr1_a", a_ready_o, 1); chk("rr1_b", b_ready_o, 0);
        step(); a_rd_i = 5; a_data_i = 32'hA000_0005;
        @(negedge clk_i); chk("rr2_b", b_ready_o, 1); chk("rr2_a", a_ready_o, 0);
        chk("rr2_wen", wen_o, 1); chk("rr2_rd", rd_o, 1); chk("rr2_wdata", wdata_o, 32'hA000_0001);
        step(); b_rd_i = 6; b_data_i = 32'hB000_0006;
        @(negedge clk_i); chk("rr3_a", a_ready_o, 1); chk("rr3_rd", rd_o, 2);
        chk("rr3_wdata", wdata_o, 32'hB000_0002);
        step(); a_rd_i = 8; a_data_i = 32'hA000_0008;
        @(negedge clk_i); chk("rr4_b", b_ready_o, 1); chk("rr4_a", a_ready_o, 0); chk("rr4_rd", rd_o, 5);
        step(); b_valid_i = 0;
        @(negedge clk_i); chk("rr5_a", a_ready_o, 1); chk("rr5_rd", rd_o, 6);
        step(); a_valid_i = 0;
        @(negedge clk_i); chk("rr6_rd", rd_o, 8); chk("rr6_pending", pending_o, 32'h100);
        step();
        // RAW on x3 resolved by an EXU writeback.
        set_iss(1, 1, 3, 0, 0);
        @(negedge clk_i); chk("raw_issue", iss_stall_o, 0);
        step(); set_iss(1, 0, 0, 3, 0);
        a_valid_i = 1; a_rd_i = 3; a_data_i = 32'hDEAD_BEEF;
        @(negedge clk_i); chk("raw_pend3", pending_o[3], 1); chk("raw_stall", iss_stall_o, 1);
        chk("raw_a_ready", a_ready_o, 1);
        step(); a_valid_i = 0;
        @(negedge clk_i); chk("raw_wen", wen_o, 1); chk("raw_rd", rd_o, 3);
        chk("raw_wdata", wdata_o, 32'hDEAD_BEEF);
`ifdef YSYX_23060251_WB_BYPASS_EN
        chk("raw_byp_stall", iss_stall_o, 0); chk("raw_fwd1_data", fwd1_data_o, 32'hDEAD_BEEF);
        chk("raw_fwd1_en", fwd1_en_o, 1);
`else
        chk("raw_wen_cycle_stall", iss_stall_o, 1);
`endif
        step();
        @(negedge clk_i); chk("raw_released", iss_stall_o, 0); chk("raw_pend3_clr", pending_o[3], 0);
        step();
        // Writeback to x0 is acked but never written.
        set_iss(1, 1, 10, 0, 0); step(); set_iss(0, 0, 0, 0, 0);
        b_valid_i = 1; b_rd_i = 0; b_data_i = 32'h1234;
        @(negedge clk_i); chk("x0_b_ready", b_ready_o, 1);
        step(); b_valid_i = 0;
        @(negedge clk_i); chk("x0_wen", wen_o, 0); chk("x0_pending", pending_o, 32'h400);
        step();
        // WAW on x7 released only after the LSU write commits.
        set_iss(1, 1, 7, 0, 0); step();
        b_valid_i = 1; b_rd_i = 7; b_data_i = 32'h77;
        @(negedge clk_i); chk("waw_stall", iss_stall_o, 1); chk("waw_b_ready", b_ready_o, 1);
        step(); b_valid_i = 0;
        @(negedge clk_i); chk("waw_wen", wen_o, 1); chk("waw_rd", rd_o, 7);
        chk("waw_wen_cycle_stall", iss_stall_o, 1);
        step();
        @(negedge clk_i); chk("waw_reissue", iss_stall_o, 0);
        step(); set_iss(0, 0, 0, 0, 0);
        @(negedge clk_i); chk("waw_pending", pending_o, 32'h480);
        // Same-cycle set of x9 and clear of x4.
        set_iss(1, 1, 4, 0, 0); step(); set_iss(0, 0, 0, 0, 0);
        a_valid_i = 1; a_rd_i = 4; a_data_i = 32'h44;
        @(negedge clk_i); chk("sc_a_ready", a_ready_o, 1);
        step(); a_valid_i = 0; set_iss(1, 1, 9, 0, 0);
        @(negedge clk_i); chk("sc_wen", wen_o, 1); chk("sc_rd", rd_o, 4); chk("sc_stall", iss_stall_o, 0);
        step(); set_iss(0, 0, 0, 0, 0);
        @(negedge clk_i); chk("sc_pending", pending_o, 32'h680);
        // Asynchronous reset while a write to x5 is on the port.
        set_iss(1, 1, 5, 0, 0); step(); set_iss(0, 0, 0, 0, 0);
        a_valid_i = 1; a_rd_i = 5; a_data_i = 32'h55;
        step(); a_valid_i = 0;
        #1 chk("mid_pre_wen", wen_o, 1);
        rst_i = 0;
        #1 chk("mid_wen", wen_o, 0); chk("mid_pending", pending_o, 0);
        step(); rst_i = 1; a_valid_i = 1; a_rd_i = 0; a_data_i = 32'h9;
        @(negedge clk_i); chk("mid_post_a_ready", a_ready_o, 1);
        step(); a_valid_i = 0;
        // Random traffic; writebacks only target destinations the bench issued.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!a_valid_i && qa.size() != 0 && $urandom_range(3) != 0) begin
                a_valid_i = 1; a_rd_i = qa.pop_front(); a_data_i = $urandom;
            end else if (!a_valid_i && $urandom_range(30) == 0) begin
                a_valid_i = 1; a_rd_i = 0; a_data_i = $urandom;
            end
            if (!b_valid_i && qb.size() != 0 && $urandom_range(3) != 0) begin
                b_valid_i = 1; b_rd_i = qb.pop_front(); b_data_i = $urandom;
            end else if (!b_valid_i && $urandom_range(30) == 0) begin
                b_valid_i = 1; b_rd_i = 0; b_data_i = $urandom;
            end
            set_iss(cyc < 2600 && $urandom_range(3) != 0, $urandom_range(3) != 0,
                    rnd_idx(), rnd_idx(), rnd_idx());
            @(negedge clk_i);
            s_stall = iss_stall_o; s_ar = a_ready_o; s_br = b_ready_o;
            step();
            if (iss_valid_i && iss_wen_i && !s_stall && iss_rd_i != 0) begin
                if ($urandom_range(1) == 0) qa.push_back(iss_rd_i);
                else qb.push_back(iss_rd_i);
            end
            if (s_ar) a_valid_i = 0;
            if (s_br) b_valid_i = 0;
        end
        set_iss(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
